// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, timing defaults and command decoding for the LCD bus scheduler
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_EN_HIGH = 12;
  localparam int DEF_T_HOLD = 2;
  localparam int DEF_T_WAIT_SHORT = 2000;
  localparam int DEF_T_WAIT_LONG = 82000;
  localparam int DEF_CNT_W = 17;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME = 8'h02;
  localparam logic [7:0] HOME_ALT = 8'h03;
  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON = 8'h0C;
  localparam logic [7:0] ENTRY = 8'h06;
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CLEAR || data == HOME || data == HOME_ALT);
  endfunction
endpackage

// File: rtl/lcd_rr_arbiter2.sv
// lcd_rr_arbiter2: two-way round-robin grant, only while the scheduler is idle
module lcd_rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic last_b;
  assign gnt_a = en && req_a && (!req_b || last_b);
  assign gnt_b = en && req_b && !gnt_a;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_b <= 1'b1;
    else if (gnt_a || gnt_b) last_b <= gnt_b;
endmodule

// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: shares the HD44780 bus between two requesters and owns all bus timing
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_EN_HIGH = DEF_T_EN_HIGH,
  parameter int T_HOLD = DEF_T_HOLD,
  parameter int T_WAIT_SHORT = DEF_T_WAIT_SHORT,
  parameter int T_WAIT_LONG = DEF_T_WAIT_LONG,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  input  logic       a_rs,
  input  logic [7:0] a_data,
  output logic       a_ready,
  output logic       a_done,
  input  logic       b_valid,
  input  logic       b_rs,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       b_done,
  output logic       busy,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, lim;
  logic idle, last, gnt_a, gnt_b, long_cmd, owner_b, fin, sel_rs;
  logic [7:0] sel_data;
  assign idle = state == IDLE;
  assign lcd_rw = 1'b0;
  lcd_rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (idle),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );
  always_comb begin
    sel_rs = gnt_a ? a_rs : b_rs;
    sel_data = gnt_a ? a_data : b_data;
    lim = state == SETUP ? CNT_W'(T_SETUP) :
          state == PULSE ? CNT_W'(T_EN_HIGH) :
          state == HOLD  ? CNT_W'(T_HOLD) :
          long_cmd       ? CNT_W'(T_WAIT_LONG) : CNT_W'(T_WAIT_SHORT);
    last = (cnt + 1'b1) == lim;
    cnt_n = (idle || last) ? '0 : cnt + 1'b1;
    state_n = state;
    case (state)
      IDLE:    state_n = (gnt_a || gnt_b) ? SETUP : IDLE;
      SETUP:   state_n = last ? PULSE : SETUP;
      PULSE:   state_n = last ? HOLD : PULSE;
      HOLD:    state_n = last ? WAIT : HOLD;
      WAIT:    state_n = last ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // Status outputs trail the state register by one cycle so every output is a flop;
  // the extra setup cycle this adds is the grant cycle itself.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      busy <= 1'b0;
      lcd_en <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_data <= '0;
      long_cmd <= 1'b0;
      owner_b <= 1'b0;
      fin <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      a_ready <= gnt_a;
      b_ready <= gnt_b;
      busy <= !idle;
      lcd_en <= state == PULSE;
      fin <= state == WAIT && last;
      a_done <= fin && !owner_b;
      b_done <= fin && owner_b;
      if (gnt_a || gnt_b) begin
        lcd_rs <= sel_rs;
        lcd_data <= sel_data;
        long_cmd <= is_long_cmd(sel_rs, sel_data);
        owner_b <= gnt_b;
      end
    end
endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler: scenario tests plus a randomized run against a timing model of the scheduler
module tb_lcd_bus_scheduler;
  localparam int TS = 2, TE = 12, TH = 2, TWS = 40, TWL = 150;
  localparam int TOT_S = TS + TE + TH + TWS;
  localparam int TOT_L = TS + TE + TH + TWL;

  logic clk, reset;
  logic a_valid, a_rs, a_ready, a_done;
  logic b_valid, b_rs, b_ready, b_done;
  logic [7:0] a_data, b_data, lcd_data;
  logic busy, lcd_en, lcd_rs, lcd_rw;
  logic [15:0] outs;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  assign outs = {a_ready, a_done, b_ready, b_done, busy, lcd_en, lcd_rs, lcd_rw, lcd_data};

  lcd_bus_scheduler #(
    .T_SETUP(TS), .T_EN_HIGH(TE), .T_HOLD(TH),
    .T_WAIT_SHORT(TWS), .T_WAIT_LONG(TWL), .CNT_W(17)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data), .a_ready(a_ready), .a_done(a_done),
    .b_valid(b_valid), .b_rs(b_rs), .b_data(b_data), .b_ready(b_ready), .b_done(b_done),
    .busy(busy), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    a_valid = 0; a_rs = 0; a_data = 0;
    b_valid = 0; b_rs = 0; b_data = 0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  function automatic bit long_exp(input bit rs, input logic [7:0] d);
    return !rs && d >= 8'h01 && d <= 8'h03;
  endfunction

  task automatic test_reset;
    do_reset;
    reset = 1'b1;
    tick;
    n_cmp++;
    if (outs !== 16'h0) begin n_bad++; $display("FAIL reset_values got=%h exp=0000", outs); end
    reset = 1'b0;
    repeat (3) tick;
    n_cmp++;
    if (outs !== 16'h0) begin n_bad++; $display("FAIL idle_no_request got=%h exp=0000", outs); end
  endtask

  task automatic test_short_cmd;
    bit en_e;
    a_valid = 1; a_rs = 0; a_data = 8'h38;
    tick;
    n_cmp++;
    if (a_ready !== 1'b1) begin n_bad++; $display("FAIL short_ready got=%b exp=1", a_ready); end
    a_valid = 0;
    for (int r = 1; r <= TOT_S + 3; r++) begin
      tick;
      en_e = r >= TS + 1 && r <= TS + TE;
      n_cmp++;
      if (lcd_en !== en_e) begin n_bad++; $display("FAIL short_en r=%0d got=%b exp=%b", r, lcd_en, en_e); end
      n_cmp++;
      if ({a_ready, a_done, b_ready, b_done} !== {1'b0, r == TOT_S + 1, 2'b00})
        begin n_bad++; $display("FAIL short_flags r=%0d got=%b%b%b%b", r, a_ready, a_done, b_ready, b_done); end
      n_cmp++;
      if ({lcd_rw, lcd_rs, lcd_data} !== 10'h038)
        begin n_bad++; $display("FAIL short_bus r=%0d got=%b%b%h exp=0038", r, lcd_rw, lcd_rs, lcd_data); end
      n_cmp++;
      if (busy !== (r <= TOT_S)) begin n_bad++; $display("FAIL short_busy r=%0d got=%b", r, busy); end
    end
  endtask

  task automatic test_long_cmd;
    bit en_e;
    a_valid = 1; a_rs = 0; a_data = 8'h01;
    tick;
    n_cmp++;
    if (a_ready !== 1'b1) begin n_bad++; $display("FAIL long_ready got=%b exp=1", a_ready); end
    a_valid = 0;
    for (int r = 1; r <= TOT_L + 1; r++) begin
      if (r == 30) begin b_valid = 1; b_rs = 1; b_data = 8'h42; end
      tick;
      en_e = r >= TS + 1 && r <= TS + TE;
      n_cmp++;
      if (lcd_en !== en_e) begin n_bad++; $display("FAIL long_en r=%0d got=%b exp=%b", r, lcd_en, en_e); end
      n_cmp++;
      if ({a_ready, a_done, b_ready, b_done} !== {1'b0, r == TOT_L + 1, r == TOT_L + 1, 1'b0})
        begin n_bad++; $display("FAIL long_flags r=%0d got=%b%b%b%b", r, a_ready, a_done, b_ready, b_done); end
    end
    b_valid = 0;
    for (int r = 1; r <= TOT_S + 1; r++) begin
      tick;
      n_cmp++;
      if ({lcd_rw, lcd_rs, lcd_data} !== 10'h142)
        begin n_bad++; $display("FAIL data_bus r=%0d got=%b%b%h exp=0142", r, lcd_rw, lcd_rs, lcd_data); end
      n_cmp++;
      if ({a_ready, a_done, b_ready, b_done} !== {3'b000, r == TOT_S + 1})
        begin n_bad++; $display("FAIL data_flags r=%0d got=%b%b%b%b", r, a_ready, a_done, b_ready, b_done); end
    end
  endtask

  task automatic test_alternate;
    int prev, t;
    bit is_b;
    reset = 1'b1;
    a_valid = 1; a_rs = 1; a_data = 8'h61;
    b_valid = 1; b_rs = 1; b_data = 8'h62;
    tick;
    tick;
    reset = 1'b0;
    prev = cyc;
    for (int gi = 0; gi < 4; gi++) begin
      for (t = 0; t < 300; t++) begin
        tick;
        if (a_ready || b_ready) break;
      end
      n_cmp++;
      if (t == 300) begin n_bad++; $display("FAIL alt_timeout grant=%0d", gi); return; end
      is_b = b_ready;
      n_cmp++;
      if ({a_ready, b_ready} !== {gi[0] == 1'b0, gi[0] == 1'b1})
        begin n_bad++; $display("FAIL alt_order grant=%0d got a=%b b=%b", gi, a_ready, b_ready); end
      n_cmp++;
      if (cyc - prev !== (gi == 0 ? 1 : TOT_S + 1))
        begin n_bad++; $display("FAIL alt_gap grant=%0d got=%0d exp=%0d", gi, cyc - prev, gi == 0 ? 1 : TOT_S + 1); end
      prev = cyc;
      tick;
      n_cmp++;
      if (lcd_data !== (is_b ? 8'h62 : 8'h61))
        begin n_bad++; $display("FAIL alt_data grant=%0d got=%h", gi, lcd_data); end
    end
    a_valid = 0;
    b_valid = 0;
    repeat (TOT_S + 2) tick;
  endtask

  task automatic test_reset_mid_pulse;
    a_valid = 1; a_rs = 0; a_data = 8'h0C;
    tick;
    n_cmp++;
    if (a_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b exp=1", a_ready); end
    a_valid = 0;
    repeat (TS + 4) tick;
    n_cmp++;
    if (lcd_en !== 1'b1) begin n_bad++; $display("FAIL abort_in_pulse got=%b exp=1", lcd_en); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 16'h0) begin n_bad++; $display("FAIL async_reset got=%h exp=0000", outs); end
    tick;
    reset = 1'b0;
    for (int r = 0; r < TOT_S + 5; r++) begin
      tick;
      n_cmp++;
      if (outs !== 16'h0) begin n_bad++; $display("FAIL abort_no_done r=%0d got=%h exp=0000", r, outs); end
    end
    a_valid = 1; a_rs = 0; a_data = 8'h06;
    tick;
    n_cmp++;
    if (a_ready !== 1'b1) begin n_bad++; $display("FAIL after_abort_ready got=%b exp=1", a_ready); end
    a_valid = 0;
    for (int r = 1; r <= TOT_S + 1; r++) begin
      tick;
      n_cmp++;
      if (a_done !== (r == TOT_S + 1)) begin n_bad++; $display("FAIL after_abort_done r=%0d got=%b", r, a_done); end
    end
  endtask

  task automatic test_withdraw;
    a_valid = 1; a_rs = 0; a_data = 8'h38;
    tick;
    n_cmp++;
    if (a_ready !== 1'b1) begin n_bad++; $display("FAIL wd_ready got=%b exp=1", a_ready); end
    a_valid = 0;
    for (int r = 1; r <= TOT_S + 12; r++) begin
      if (r == 10) begin b_valid = 1; b_rs = 1; b_data = 8'h55; end
      if (r == 15) b_valid = 0;
      tick;
      n_cmp++;
      if ({a_ready, a_done, b_ready, b_done} !== {1'b0, r == TOT_S + 1, 2'b00})
        begin n_bad++; $display("FAIL wd_flags r=%0d got=%b%b%b%b", r, a_ready, a_done, b_ready, b_done); end
      n_cmp++;
      if (busy !== (r <= TOT_S)) begin n_bad++; $display("FAIL wd_busy r=%0d got=%b", r, busy); end
    end
  endtask

  task automatic test_random;
    bit sa, sb, ga, gb, dn, free, own, last_b, exp_rs, en_e, busy_e;
    logic [7:0] exp_d;
    int g, tot, k;
    do_reset;
    g = -1; tot = 0; own = 0; last_b = 1; exp_rs = 0; exp_d = 0;
    for (int i = 0; i < 4000; i++) begin
      sa = a_valid;
      sb = b_valid;
      tick;
      k = cyc;
      free = g < 0 || k >= g + tot + 1;
      ga = free && sa && (!sb || last_b);
      gb = free && sb && !ga;
      dn = g >= 0 && k == g + tot + 1;
      n_cmp++;
      if ({a_ready, a_done, b_ready, b_done} !== {ga, dn && !own, gb, dn && own})
        begin n_bad++; $display("FAIL rnd_flags i=%0d got=%b%b%b%b exp=%b%b%b%b", i,
          a_ready, a_done, b_ready, b_done, ga, dn && !own, gb, dn && own); end
      en_e = g >= 0 && k - g >= TS + 1 && k - g <= TS + TE;
      n_cmp++;
      if (lcd_en !== en_e) begin n_bad++; $display("FAIL rnd_en i=%0d got=%b exp=%b", i, lcd_en, en_e); end
      busy_e = g >= 0 && k > g && k <= g + tot;
      n_cmp++;
      if (busy !== busy_e) begin n_bad++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, busy_e); end
      n_cmp++;
      if (lcd_rw !== 1'b0) begin n_bad++; $display("FAIL rnd_rw i=%0d got=%b exp=0", i, lcd_rw); end
      if (g >= 0 && !(ga || gb)) begin
        n_cmp++;
        if ({lcd_rs, lcd_data} !== {exp_rs, exp_d})
          begin n_bad++; $display("FAIL rnd_bus i=%0d got=%b%h exp=%b%h", i, lcd_rs, lcd_data, exp_rs, exp_d); end
      end
      if (ga || gb) begin
        g = k;
        own = gb;
        last_b = gb;
        exp_rs = ga ? a_rs : b_rs;
        exp_d = ga ? a_data : b_data;
        tot = TS + TE + TH + (long_exp(exp_rs, exp_d) ? TWL : TWS);
      end
      if (ga) a_valid = 0;
      else if (!a_valid && $urandom_range(0, 5) == 0) begin
        a_valid = 1;
        a_rs = 1'($urandom_range(0, 1));
        a_data = $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 3)) : 8'($urandom);
      end
      if (gb) b_valid = 0;
      else if (!b_valid && $urandom_range(0, 5) == 0) begin
        b_valid = 1;
        b_rs = 1'($urandom_range(0, 1));
        b_data = $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 3)) : 8'($urandom);
      end
    end
  endtask

  initial begin
    test_reset;
    test_short_cmd;
    test_long_cmd;
    test_alternate;
    test_reset_mid_pulse;
    test_withdraw;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
